// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM read-channel arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arbState_t;

  localparam int SRAM_ADDR_W = 32;
  localparam int SRAM_DATA_W = 128;
  localparam int MAX_MASTERS = 4;

endpackage

// File: rtl/sram_read_arbiter_if.sv
// Requester-side and SRAM-side read-channel signals of the arbiter.
interface sram_read_arbiter_if
  import sram_arb_pkg::*;
#(
  parameter int N_MASTERS = 2
) ();

  logic [SRAM_ADDR_W*N_MASTERS-1:0] m_readAddr_addr;
  logic [N_MASTERS-1:0]             m_readAddr_valid;
  logic [N_MASTERS-1:0]             m_readAddr_ready;
  logic [SRAM_DATA_W-1:0]           m_readData_data;
  logic [N_MASTERS-1:0]             m_readData_valid;
  logic [N_MASTERS-1:0]             m_readData_ready;
  logic [SRAM_ADDR_W-1:0]           s_readAddr_addr;
  logic                             s_readAddr_valid;
  logic                             s_readAddr_ready;
  logic [SRAM_DATA_W-1:0]           s_readData_data;
  logic                             s_readData_valid;
  logic                             s_readData_ready;

  // Arbiter view.
  modport slave (
    input  m_readAddr_addr, m_readAddr_valid, m_readData_ready,
           s_readAddr_ready, s_readData_data, s_readData_valid,
    output m_readAddr_ready, m_readData_data, m_readData_valid,
           s_readAddr_addr, s_readAddr_valid, s_readData_ready
  );

  // Environment view: requesters plus the SRAM.
  modport master (
    output m_readAddr_addr, m_readAddr_valid, m_readData_ready,
           s_readAddr_ready, s_readData_data, s_readData_valid,
    input  m_readAddr_ready, m_readData_data, m_readData_valid,
           s_readAddr_addr, s_readAddr_valid, s_readData_ready
  );

endinterface

// File: rtl/sram_read_arbiter_pick.sv
// Combinational winner picker: round-robin from ptr, or lowest index when
// SRAM_ARB_FIXED_PRIO_EN is defined.
module sram_arb_pick
  import sram_arb_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ID_W      = 2
) (
  input  logic [N_MASTERS-1:0] req,
  input  logic [ID_W-1:0]      ptr,
  output logic [ID_W-1:0]      winner,
  output logic                 found
);

`ifdef SRAM_ARB_FIXED_PRIO_EN
  logic unusedPtr;
  assign unusedPtr = ^ptr;

  always_comb begin
    logic [N_MASTERS-1:0] reqShift;
    winner   = '0;
    found    = 1'b0;
    reqShift = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      reqShift = req >> k;
      if (!found && reqShift[0]) begin
        found  = 1'b1;
        winner = ID_W'(k);
      end
    end
  end
`else
  // Search upward from the pointer, wrapping past the top index.
  always_comb begin
    logic [N_MASTERS-1:0] reqShift;
    int idx;
    winner   = '0;
    found    = 1'b0;
    reqShift = '0;
    idx      = 0;
    for (int k = 0; k < N_MASTERS; k++) begin
      idx      = (int'(ptr) + k) % N_MASTERS;
      reqShift = req >> idx;
      if (!found && reqShift[0]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end
`endif

endmodule

// File: rtl/sram_read_arbiter.sv
// One-at-a-time AXI-Lite read arbiter for the SRAM; round-robin by default,
// fixed priority when SRAM_ARB_FIXED_PRIO_EN is defined.
module sram_read_arbiter
  import sram_arb_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ID_W      = 2
) (
  input  logic                clk,
  input  logic                n_rst,
  sram_read_arbiter_if.slave  bus,
  output logic [ID_W-1:0]     grant_id
);

  arbState_t              state, stateNext;
  logic [ID_W-1:0]        rrPtr, winner, ptrNext;
  logic                   found, accept, addrDone, dataDone;
  logic [SRAM_ADDR_W-1:0] addrSel;
  logic [N_MASTERS-1:0]   winHot, grantHot;

  sram_arb_pick #(
    .N_MASTERS (N_MASTERS),
    .ID_W      (ID_W)
  ) uPick (
    .req    (bus.m_readAddr_valid),
    .ptr    (rrPtr),
    .winner (winner),
    .found  (found)
  );

  assign winHot   = N_MASTERS'(1) << winner;
  assign grantHot = N_MASTERS'(1) << grant_id;
  assign addrSel  = bus.m_readAddr_addr[int'(winner)*SRAM_ADDR_W +: SRAM_ADDR_W];
  assign ptrNext  = (grant_id == ID_W'(N_MASTERS-1)) ? '0 : grant_id + 1'b1;

  assign accept   = (state == IDLE) && found;
  assign addrDone = (state == ADDR) && bus.s_readAddr_ready;
  assign dataDone = (state == DATA) && bus.s_readData_valid && bus.s_readData_ready;

  assign bus.m_readData_data = bus.s_readData_data;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (found)    stateNext = ADDR;
      ADDR:    if (addrDone) stateNext = DATA;
      DATA:    if (dataDone) stateNext = IDLE;
      default:               stateNext = IDLE;
    endcase
  end

  // Readies and data valid only ever reach the granted master.
  always_comb begin
    bus.m_readAddr_ready = '0;
    bus.m_readData_valid = '0;
    bus.s_readData_ready = 1'b0;
    case (state)
      IDLE: if (found) bus.m_readAddr_ready = winHot;
      DATA: begin
        bus.m_readData_valid = bus.s_readData_valid ? grantHot : '0;
        bus.s_readData_ready = |(bus.m_readData_ready & grantHot);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      grant_id             <= '0;
      rrPtr                <= '0;
      bus.s_readAddr_addr  <= '0;
      bus.s_readAddr_valid <= 1'b0;
    end else begin
      if (accept) begin
        bus.s_readAddr_addr  <= addrSel;
        bus.s_readAddr_valid <= 1'b1;
        grant_id             <= winner;
      end
      if (addrDone) bus.s_readAddr_valid <= 1'b0;
`ifdef SRAM_ARB_FIXED_PRIO_EN
      rrPtr <= '0;
`else
      if (dataDone) rrPtr <= ptrNext;
`endif
    end
  end

endmodule

// File: doc/sram_read_arbiter.md
# sram_read_arbiter

Arbitrates the single AXI-Lite read channel of the 64 KiB SRAM among `N_MASTERS` requesters, for example instruction fetch, data load, and DMA read. It sits between the requesters and the SRAM read-address and read-data channels, and runs one transaction at a time. Each transaction is address handshake, then data handshake. Grant order is round-robin by default and fixed-priority when configured. The SRAM write path is out of scope; it stays single-master.

## Interface
- `N_MASTERS`, default 2, legal range 2..4: number of requesters.
- `ID_W`, default 2: width of `grant_id`; must satisfy 2^`ID_W` ≥ `N_MASTERS`.
- `clk` in 1: clock; all state is updated on the rising edge.
- `n_rst` in 1: reset, asynchronous, active-low.
- `m_readAddr_addr` in 32·N: per-master address; master i occupies bits [32i+31:32i].
- `m_readAddr_valid` in N: per-master request valid.
- `m_readAddr_ready` out N: one-hot accept pulse to the granted master.
- `m_readData_data` out 128: broadcast copy of `s_readData_data`.
- `m_readData_valid` out N: data valid, routed only to the granted master.
- `m_readData_ready` in N: per-master data ready.
- `s_readAddr_addr` out 32: address presented to the SRAM.
- `s_readAddr_valid` out 1: address valid to the SRAM.
- `s_readAddr_ready` in 1: SRAM address ready.
- `s_readData_data` in 128: SRAM read data.
- `s_readData_valid` in 1: SRAM data valid.
- `s_readData_ready` out 1: ready to the SRAM.
- `grant_id` out `ID_W`: index of the current or most recent grant; held between transactions.

## Operation
- **FSM states:** IDLE, ADDR, DATA.
- **IDLE**
  - If any `m_readAddr_valid` bit is set, the picker selects winner g.
  - `m_readAddr_ready[g]` = 1 combinationally in this cycle only.
  - At the clock edge: latch the address into `s_readAddr_addr`, set `grant_id` = g, set `s_readAddr_valid` = 1, and go to ADDR.
  - With no request, stay in IDLE with all readies 0.
- **ADDR**
  - Hold `s_readAddr_addr` and `s_readAddr_valid` stable.
  - When `s_readAddr_ready` = 1: clear `s_readAddr_valid` at the edge and go to DATA.
- **DATA**
  - `m_readData_valid[grant_id]` = `s_readData_valid`.
  - `s_readData_ready` = `m_readData_ready[grant_id]`.
  - All other bits of `m_readData_valid` are 0.
  - When `s_readData_valid` and `s_readData_ready` are both 1, the transaction completes: go to IDLE, and set the round-robin pointer to (`grant_id` + 1) mod N.
- **Round-robin pick:** the first requesting index found by searching upward from the pointer, wrapping from N−1 to 0.
- **Outside DATA:** `s_readData_ready` = 0, all `m_readData_valid` bits = 0, and `s_readData_valid` is ignored.
- **Master drops `m_readAddr_valid` before being granted:** no transaction is started for it; the picker only considers requests valid in the current cycle.
- **Granted master holds `m_readData_ready` low:** the block stays in DATA indefinitely, and the SRAM holds its data.
- **Ungranted masters:** their `m_readAddr_valid` is ignored while the block is in ADDR or DATA; no acceptance is issued to them.

## Timing
- **Reset values** (with `n_rst` low, asynchronously):
  - FSM = IDLE, pointer = 0, `grant_id` = 0.
  - `s_readAddr_valid` = 0, `s_readAddr_addr` = 0.
  - All combinational outputs also evaluate to 0 in IDLE: `m_readAddr_ready`, `m_readData_valid`, `s_readData_ready`.
  - `m_readData_data` follows `s_readData_data` at all times.
- **Reset in the middle of a transaction:** the transaction is abandoned, no `m_readData_valid` is issued, and the FSM returns to IDLE.
- **Latency, with the SRAM idle:**
  - Cycle 0: master accepted.
  - Cycle 1: `s_readAddr_valid` = 1 and the SRAM accepts.
  - Cycle 3: SRAM `readData_valid` is forwarded combinationally.
  - The arbiter adds exactly one cycle of latency versus a direct connection.
- **Back-to-back transactions:** the next acceptance can occur in the cycle after completion, since IDLE is re-entered first. Minimum spacing is 4 cycles per transaction.
- **Simultaneous requests:** exactly one winner per IDLE cycle.

## Configuration
- **`SRAM_ARB_FIXED_PRIO_EN` defined:** the lowest requesting index always wins, and the pointer is not updated. Starvation of higher indices is permitted.
- **Not defined:** round-robin as described in Operation.

## Structure
- **Package `sram_arb_pkg`:**
  - State enum {IDLE, ADDR, DATA}.
  - `SRAM_ADDR_W` = 32 and `SRAM_DATA_W` = 128.
  - `MAX_MASTERS` = 4.
- **Sub-module `sram_arb_pick`:** combinational.
  - Inputs: request vector and pointer.
  - Outputs: winner index and a found flag.
  - Holds the round-robin versus fixed-priority logic selected by the macro.

## Test plan
- **Single request:** master 1 reads 0x0040 on an idle bus → `m_readAddr_ready` = 2'b10 for 1 cycle; `s_readAddr_addr` = 0x0040 at cycle 1; `m_readData_valid[1]` goes high at cycle 3 with the SRAM data; `grant_id` = 1.
- **Contention, round-robin:** both masters request continuously for 4 transactions → grants go 0, 1, 0, 1.
- **Contention, `SRAM_ARB_FIXED_PRIO_EN`:** same stimulus → grants go 0, 0, 0, 0.
- **Backpressure:** granted master 0 holds `m_readData_ready` = 0 for 5 cycles after SRAM data is valid → `s_readData_ready` = 0 during those cycles, the FSM stays in DATA, and the transaction completes on the cycle ready rises.
- **Withdrawn request:** master 1 asserts valid for 1 cycle while master 0 is in DATA, then drops it → master 1 is never granted, and `m_readAddr_ready[1]` stays 0.
- **Reset in ADDR:** `n_rst` is pulsed low while in ADDR → `s_readAddr_valid` = 0 immediately, `grant_id` = 0, and no `m_readData_valid` pulse is issued.
